// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons with shift leak,
// refractory hold, two reset modes and a saturating spike counter.
module lif_neuron_array #(
  parameter int N_NEURONS   = 2,
  parameter int WIDTH       = 8,
  parameter int REFRAC_BITS = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_NEURONS*WIDTH-1:0]   current,
  input  logic [2:0]                   beta,
  input  logic [WIDTH-1:0]             threshold,
  input  logic [REFRAC_BITS-1:0]       refrac_len,
  input  logic                         reset_mode,
  input  logic                         cnt_clr,
  output logic [N_NEURONS-1:0]         spike,
  output logic [N_NEURONS*WIDTH-1:0]   state,
  output logic [CNT_WIDTH-1:0]         spike_total
);

  localparam int POP_W = 4;

  logic [N_NEURONS-1:0] fire_v;
  logic [N_NEURONS-1:0] spike_d;
  logic [N_NEURONS-1:0] spike_q;
  logic [POP_W-1:0]     pop;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
    logic [WIDTH-1:0]       mem_q;
    logic [WIDTH-1:0]       mem_d;
    logic [WIDTH-1:0]       cur;
    logic [WIDTH-1:0]       leaked;
    logic [WIDTH:0]         sum_wide;
    logic [WIDTH-1:0]       sum_sat;
    logic [REFRAC_BITS-1:0] ref_q;
    logic [REFRAC_BITS-1:0] ref_d;
    logic                   refractory;
    logic                   fire;

    assign cur = current[g*WIDTH +: WIDTH];

    // Leak, integrate (unless refractory), saturate, threshold test
    always_comb begin
      leaked     = mem_q - (mem_q >> beta);
      refractory = (ref_q != '0);
      sum_wide   = {1'b0, leaked};
      if (!refractory) begin
        sum_wide = {1'b0, leaked} + {1'b0, cur};
      end
      sum_sat = sum_wide[WIDTH-1:0];
      if (sum_wide[WIDTH]) begin
        sum_sat = '1;
      end
      fire  = !refractory && (sum_sat >= threshold);
      mem_d = sum_sat;
      ref_d = ref_q;
      if (refractory) begin
        ref_d = ref_q - 1'b1;
      end else if (fire) begin
        ref_d = refrac_len;
        mem_d = reset_mode ? '0 : (sum_sat - threshold);
      end
    end

    // Membrane and refractory registers, frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q <= '0;
        ref_q <= '0;
      end else if (en) begin
        mem_q <= mem_d;
        ref_q <= ref_d;
      end
    end

    assign fire_v[g]               = fire;
    assign state[g*WIDTH +: WIDTH] = mem_q;
  end

  assign spike_d = en ? fire_v : '0;

  // Number of spikes being registered this edge
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      pop = pop + {{(POP_W-1){1'b0}}, spike_d[i]};
    end
  end

  // Saturating accumulate; clear wins over same-cycle spikes
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {{(CNT_WIDTH+1-POP_W){1'b0}}, pop};
    cnt_d   = cnt_sum[CNT_WIDTH-1:0];
    if (cnt_sum[CNT_WIDTH]) begin
      cnt_d = '1;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  // Spike flags and spike counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q <= '0;
      cnt_q   <= '0;
    end else begin
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spike       = spike_q;
  assign spike_total = cnt_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios
// plus randomized traffic against a behavioural neuron model.
module tb_lif_neuron_array;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int RB = 3;
  localparam int CW = 16;

  logic          clk = 0;
  logic          rst = 1;
  logic          en = 0;
  logic [N*W-1:0] current = '0;
  logic [2:0]    beta = 3'd3;
  logic [W-1:0]  threshold = 8'd100;
  logic [RB-1:0] refrac_len = '0;
  logic          reset_mode = 0;
  logic          cnt_clr = 0;
  logic [N-1:0]  spike;
  logic [N*W-1:0] state;
  logic [CW-1:0] spike_total;

  int compared = 0;
  int mismatched = 0;

  int m_st[N];
  int m_rc[N];
  int m_sp[N];
  int m_tot;

  lif_neuron_array #(
    .N_NEURONS(N), .WIDTH(W), .REFRAC_BITS(RB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .current(current),
    .beta(beta), .threshold(threshold), .refrac_len(refrac_len),
    .reset_mode(reset_mode), .cnt_clr(cnt_clr), .spike(spike),
    .state(state), .spike_total(spike_total)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1;
    en = 0;
    cnt_clr = 0;
    tick();
    rst = 0;
    en = 1;
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0;
      m_rc[i] = 0;
      m_sp[i] = 0;
    end
    m_tot = 0;
  endtask

  task automatic cfg(input int b, input int th, input int rl,
                     input int md, input int cur);
    beta = b[2:0];
    threshold = th[W-1:0];
    refrac_len = rl[RB-1:0];
    reset_mode = md[0];
    current = {cur[W-1:0], cur[W-1:0]};
  endtask

  // Rule-level model of one clock edge for the whole array
  task automatic model_edge();
    int lk, s, pop;
    pop = 0;
    for (int i = 0; i < N; i++) begin
      m_sp[i] = 0;
      if (en) begin
        lk = m_st[i] - (m_st[i] >> beta);
        if (m_rc[i] > 0) begin
          m_st[i] = lk;
          m_rc[i] = m_rc[i] - 1;
        end else begin
          s = lk + int'(current[i*W +: W]);
          if (s > 255) s = 255;
          if (s >= int'(threshold)) begin
            m_sp[i] = 1;
            m_st[i] = reset_mode ? 0 : s - int'(threshold);
            m_rc[i] = int'(refrac_len);
          end else begin
            m_st[i] = s;
          end
        end
      end
      pop += m_sp[i];
    end
    if (cnt_clr) m_tot = 0;
    else if (m_tot + pop > 65535) m_tot = 65535;
    else m_tot = m_tot + pop;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    compared++;
    if (state !== '0 || spike !== '0 || spike_total !== '0) begin
      mismatched++;
      $display("FAIL reset: state=%h spike=%b total=%0d want 0",
               state, spike, spike_total);
    end
    #10;
    rst = 0;
  endtask

  task automatic test_integrate_subtract();
    int exp_st[4] = '{32, 60, 85, 7};
    apply_reset();
    cfg(3, 100, 0, 0, 32);
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if (state !== {exp_st[k][W-1:0], exp_st[k][W-1:0]} ||
          spike !== ((k == 3) ? 2'b11 : 2'b00)) begin
        mismatched++;
        $display("FAIL integ e%0d: state=%h spike=%b want %0d",
                 k + 1, state, spike, exp_st[k]);
      end
    end
    compared++;
    if (spike_total !== 16'd2) begin
      mismatched++;
      $display("FAIL integ total: got %0d want 2", spike_total);
    end
  endtask

  task automatic test_zero_reset();
    apply_reset();
    cfg(3, 100, 0, 1, 32);
    repeat (4) tick();
    compared++;
    if (state !== 16'h0000 || spike !== 2'b11) begin
      mismatched++;
      $display("FAIL zero e4: state=%h spike=%b want 0/11",
               state, spike);
    end
    tick();
    compared++;
    if (state !== {8'd32, 8'd32} || spike !== 2'b00) begin
      mismatched++;
      $display("FAIL zero e5: state=%h spike=%b want 32/00",
               state, spike);
    end
  endtask

  task automatic test_refractory();
    int exp_st[4] = '{7, 7, 7, 39};
    apply_reset();
    cfg(3, 100, 2, 0, 32);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if (state !== {exp_st[k][W-1:0], exp_st[k][W-1:0]} ||
          spike !== ((k == 0) ? 2'b11 : 2'b00)) begin
        mismatched++;
        $display("FAIL refrac e%0d: state=%h spike=%b want %0d",
                 k + 4, state, spike, exp_st[k]);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    cfg(3, 255, 0, 0, 200);
    tick();
    compared++;
    if (state !== {8'd200, 8'd200} || spike !== 2'b00) begin
      mismatched++;
      $display("FAIL sat e1: state=%h spike=%b want 200/00",
               state, spike);
    end
    tick();
    compared++;
    if (state !== 16'h0000 || spike !== 2'b11) begin
      mismatched++;
      $display("FAIL sat e2: state=%h spike=%b want 0/11",
               state, spike);
    end
  endtask

  task automatic test_enable_hold();
    apply_reset();
    cfg(3, 100, 0, 0, 32);
    repeat (2) tick();
    en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      compared++;
      if (state !== {8'd60, 8'd60} || spike !== 2'b00) begin
        mismatched++;
        $display("FAIL hold c%0d: state=%h spike=%b want 60/00",
                 k, state, spike);
      end
    end
    en = 1;
    tick();
    tick();
    compared++;
    if (state !== {8'd7, 8'd7} || spike !== 2'b11 ||
        spike_total !== 16'd2) begin
      mismatched++;
      $display("FAIL hold resume: state=%h spike=%b total=%0d",
               state, spike, spike_total);
    end
  endtask

  task automatic test_cnt_clr();
    apply_reset();
    cfg(3, 100, 0, 0, 32);
    repeat (7) tick();
    compared++;
    if (spike_total !== 16'd2 || state !== {8'd91, 8'd91}) begin
      mismatched++;
      $display("FAIL clr pre: total=%0d state=%h want 2/91",
               spike_total, state);
    end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    compared++;
    if (spike_total !== 16'd0 || spike !== 2'b11 ||
        state !== {8'd12, 8'd12}) begin
      mismatched++;
      $display("FAIL clr fire: total=%0d spike=%b state=%h",
               spike_total, spike, state);
    end
  endtask

  task automatic test_counter_saturation();
    apply_reset();
    cfg(3, 0, 0, 0, 0);
    repeat (32767) tick();
    compared++;
    if (spike_total !== 16'hFFFE) begin
      mismatched++;
      $display("FAIL cntsat pre: got %h want fffe", spike_total);
    end
    repeat (3) tick();
    compared++;
    if (spike_total !== 16'hFFFF || spike !== 2'b11) begin
      mismatched++;
      $display("FAIL cntsat: got %h spike=%b want ffff/11",
               spike_total, spike);
    end
  endtask

  task automatic test_async_reset();
    int exp_st[4] = '{32, 60, 85, 7};
    apply_reset();
    cfg(3, 100, 3, 0, 32);
    repeat (5) tick();
    rst = 1;
    #2;
    compared++;
    if (state !== '0 || spike !== '0 || spike_total !== '0) begin
      mismatched++;
      $display("FAIL async: state=%h spike=%b total=%0d want 0",
               state, spike, spike_total);
    end
    tick();
    rst = 0;
    cfg(3, 100, 0, 0, 32);
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if (state !== {exp_st[k][W-1:0], exp_st[k][W-1:0]} ||
          spike !== ((k == 3) ? 2'b11 : 2'b00)) begin
        mismatched++;
        $display("FAIL async post e%0d: state=%h spike=%b want %0d",
                 k + 1, state, spike, exp_st[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [N*W-1:0] exp_st;
    logic [N-1:0]   exp_sp;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      beta = 3'($urandom_range(0, 7));
      threshold = 8'($urandom_range(0, 220));
      refrac_len = 3'($urandom_range(0, 7));
      reset_mode = 1'($urandom_range(0, 1));
      current = {8'($urandom_range(0, 90)), 8'($urandom_range(0, 255))};
      en = ($urandom_range(0, 9) != 0);
      cnt_clr = ($urandom_range(0, 29) == 0);
      model_edge();
      tick();
      for (int i = 0; i < N; i++) begin
        exp_st[i*W +: W] = m_st[i][W-1:0];
        exp_sp[i] = m_sp[i][0];
      end
      compared++;
      if (state !== exp_st || spike !== exp_sp ||
          spike_total !== m_tot[CW-1:0]) begin
        mismatched++;
        $display("FAIL rand c%0d: st=%h sp=%b tot=%0d want %h %b %0d",
                 c, state, spike, spike_total, exp_st, exp_sp, m_tot);
      end
    end
    en = 1;
    cnt_clr = 0;
  endtask

  initial begin
    test_reset();
    test_integrate_subtract();
    test_zero_reset();
    test_refractory();
    test_saturation();
    test_enable_hold();
    test_cnt_clr();
    test_counter_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised array of leaky integrate-and-fire neurons that succeeds the fixed single-neuron LIF instances used in the top-level wrapper. Each of `N_NEURONS` channels integrates its own input current with a programmable shift leak, fires a registered one-cycle spike at a programmable threshold, and then enters a programmable refractory period. Two membrane reset modes are supported, along with a saturating array-wide spike counter. The block sits between the input-pin/config logic and the output pins or a downstream neuron layer.

## Interface
- `N_NEURONS`, default 2: number of independent neurons (1..8).
- `WIDTH`, default 8: membrane/current/threshold width, unsigned.
- `REFRAC_BITS`, default 3: width of refractory length and per-neuron counter.
- `CNT_WIDTH`, default 16: width of the spike total counter.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  update enable; low freezes all neuron state.
- `current`  input  N_NEURONS*WIDTH  per-neuron input current; neuron i uses bits [i*WIDTH +: WIDTH].
- `beta`  input  3  leak shift amount; leak term = state >> beta.
- `threshold`  input  WIDTH  firing threshold, shared by all neurons.
- `refrac_len`  input  REFRAC_BITS  refractory cycles after a spike.
- `reset_mode`  input  1  0 = subtract threshold on fire, 1 = reset to zero.
- `cnt_clr`  input  1  synchronous clear of spike counter.
- `spike`  output  N_NEURONS  registered spike flags, one cycle wide.
- `state`  output  N_NEURONS*WIDTH  registered membrane potentials.
- `spike_total`  output  CNT_WIDTH  saturating count of all spikes since reset/clear.

## Operation
- Config inputs (`beta`, `threshold`, `refrac_len`, `reset_mode`) are sampled live every cycle; nothing is latched.
- Per neuron, on each enabled edge:
  - `leaked = state - (state >> beta)`. With beta=0 the leak is total, so leaked = 0.
  - If the refractory counter is nonzero: `sum = leaked` (current ignored), counter decrements, spike = 0, and no threshold test is made.
  - Else `sum = leaked + current`, computed WIDTH+1 bits wide and saturated to 2^WIDTH-1.
  - Fire when not refractory and `sum >= threshold`. Threshold 0 therefore fires every non-refractory cycle.
  - On fire: spike = 1; state = `sum - threshold` (mode 0) or 0 (mode 1); counter loads `refrac_len`.
  - If not firing: state = sum, spike = 0.
- `en` low: state and counters hold; `spike` is driven 0; `spike_total` holds (`cnt_clr` still honoured).
- `spike_total`:
  - Each edge, adds the popcount of the spikes being registered that edge, saturating at 2^CNT_WIDTH-1.
  - `cnt_clr` takes priority: counter becomes 0 and same-cycle spikes are discarded.
- Neurons are fully independent; there is no lateral coupling.

## Timing
- Reset values: `state` = 0, `spike` = 0, all refractory counters = 0, `spike_total` = 0. These take effect immediately on `rst` assertion, without a clock edge.
- Release of `rst` is synchronised by the caller; the first update occurs on the first edge with `rst` low and `en` high.
- Latency: `current` sampled at edge k appears in `state` and `spike` after edge k (1 cycle). `spike_total` reflects that spike after the same edge.
- `spike` is high for exactly one cycle per fire. Consecutive spikes are possible only when `refrac_len` = 0.
- Refractory period: after firing at edge k, edges k+1..k+refrac_len ignore current. The current is integrated again at edge k+refrac_len+1.
- `rst` asserted mid-refractory or mid-integration aborts everything to reset values.

## Test plan
- Integration/subtract mode: N=2, WIDTH=8, beta=3, threshold=100, refrac_len=0, reset_mode=0, current=32 on both neurons.
  -> state 32, 60, 85, then spike on 4th edge with state 7 on both; spike_total = 2.
- Zero-reset mode: same stimulus with reset_mode=1.
  -> 4th edge spike, state 0; 5th edge state 32.
- Refractory: as the first scenario with refrac_len=2.
  -> after the spike state 7, 7, 7 (current ignored, 7>>3=0), then 39; no spike during the two refractory edges.
- Saturation: current=200, threshold=255, beta=3.
  -> edge1 state 200, no spike; edge2 sum 375 saturates to 255, spike, state 0 (subtract).
- Enable and counter: hold `en` low for 5 cycles mid-integration.
  -> state frozen and spike 0. Drive `cnt_clr` on the same edge both neurons fire -> spike_total = 0. Preload near max with threshold=0 -> spike_total holds at 0xFFFF.
- Async reset: assert `rst` between edges during refractory.
  -> state, spike, and spike_total read 0 before the next edge; first post-reset integration matches the first scenario.
